conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 142 ++++++++++++++
 tb/tb_conv_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - KxK convolution window sequencer with tap fetch, MAC and valid/ready result
// Walks the output map in raster order, reading one tap per cycle and accumulating its product.
module conv_sequencer #(
  parameter int IP_DATA_WIDTH = 8,
  parameter int IFMAP_SIZE    = 8,
  parameter int FILTER_SIZE   = 3,
  parameter int STRIDE        = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 start,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 rd_en,
  output logic [$clog2(IFMAP_SIZE)-1:0]                        ifmap_row,
  output logic [$clog2(IFMAP_SIZE)-1:0]                        ifmap_col,
  output logic [$clog2(FILTER_SIZE*FILTER_SIZE)-1:0]           filt_idx,
  input  logic [IP_DATA_WIDTH-1:0]                             ifmap_rd_data,
  input  logic [IP_DATA_WIDTH-1:0]                             filt_rd_data,
  output logic                                                 res_valid,
  input  logic                                                 res_ready,
  output logic [2*IP_DATA_WIDTH:0]                             res_data,
  output logic [$clog2((IFMAP_SIZE-FILTER_SIZE)/STRIDE+1)-1:0] res_row,
  output logic [$clog2((IFMAP_SIZE-FILTER_SIZE)/STRIDE+1)-1:0] res_col
);

  localparam int OFMAP_SIZE = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int NTAPS      = FILTER_SIZE * FILTER_SIZE;
  localparam int AW         = $clog2(IFMAP_SIZE);
  localparam int FW         = $clog2(NTAPS);
  localparam int OW         = $clog2(OFMAP_SIZE);
  localparam int KW         = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

  state_t                   state;
  logic [KW-1:0]            j, k, j_nxt, k_nxt;
  logic [OW-1:0]            orow, ocol, orow_nxt, ocol_nxt;
  logic                     rd_valid;
  logic [2*IP_DATA_WIDTH:0] acc;
  logic [2*IP_DATA_WIDTH-1:0] product;
  logic                     last_tap, last_col, last_win;

  assign product  = ifmap_rd_data * filt_rd_data;
  assign busy     = (state != IDLE);
  assign res_data = acc;

  always_comb begin
    last_tap = (j == KW'(FILTER_SIZE - 1)) && (k == KW'(FILTER_SIZE - 1));
    k_nxt    = (k == KW'(FILTER_SIZE - 1)) ? '0 : k + 1'b1;
    j_nxt    = (k == KW'(FILTER_SIZE - 1)) ? j + 1'b1 : j;
    last_col = (ocol == OW'(OFMAP_SIZE - 1));
    ocol_nxt = last_col ? '0 : ocol + 1'b1;
    orow_nxt = last_col ? orow + 1'b1 : orow;
    last_win = last_col && (orow == OW'(OFMAP_SIZE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      j         <= '0;
      k         <= '0;
      orow      <= '0;
      ocol      <= '0;
      rd_valid  <= 1'b0;
      acc       <= '0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      ifmap_row <= '0;
      ifmap_col <= '0;
      filt_idx  <= '0;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
    end else begin
      // Read data lags rd_en by one cycle, so the product is added one cycle behind the strobe.
      rd_valid <= rd_en;
      if (rd_valid) acc <= acc + {1'b0, product};
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            orow      <= '0;
            ocol      <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            rd_en     <= 1'b1;
            ifmap_row <= '0;
            ifmap_col <= '0;
            filt_idx  <= '0;
          end
        end
        FETCH: begin
          if (last_tap) begin
            state     <= DRAIN;
            rd_en     <= 1'b0;
            ifmap_row <= '0;
            ifmap_col <= '0;
            filt_idx  <= '0;
          end else begin
            j         <= j_nxt;
            k         <= k_nxt;
            ifmap_row <= AW'(orow * STRIDE + j_nxt);
            ifmap_col <= AW'(ocol * STRIDE + k_nxt);
            filt_idx  <= FW'(j_nxt * FILTER_SIZE + k_nxt);
          end
        end
        DRAIN: begin
          state     <= OUT;
          res_valid <= 1'b1;
          res_row   <= orow;
          res_col   <= ocol;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            acc       <= '0;
            if (last_win) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= FETCH;
              orow      <= orow_nxt;
              ocol      <= ocol_nxt;
              j         <= '0;
              k         <= '0;
              rd_en     <= 1'b1;
              ifmap_row <= AW'(orow_nxt * STRIDE);
              ifmap_col <= AW'(ocol_nxt * STRIDE);
              filt_idx  <= '0;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized bench for conv_sequencer against a window-sum reference model
// Two instances: default geometry (8x8, K=3, stride 1) and a strided one (7x7, K=3, stride 2).
module tb_conv_sequencer;

  localparam int W    = 8;
  localparam int DW   = 2 * W + 1;
  localparam int KS   = 3;
  localparam int NT   = 9;
  localparam int A_SZ = 8;
  localparam int A_S  = 1;
  localparam int A_O  = 6;
  localparam int B_SZ = 7;
  localparam int B_S  = 2;
  localparam int B_O  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic          a_start, a_ready, a_busy, a_done, a_rd_en, a_res_valid;
  logic [2:0]    a_irow, a_icol, a_res_row, a_res_col;
  logic [3:0]    a_fidx;
  logic [W-1:0]  a_ifd = '0, a_fd = '0;
  logic [DW-1:0] a_res_data;
  logic [36:0]   a_outs;

  logic          b_start, b_ready, b_busy, b_done, b_rd_en, b_res_valid;
  logic [2:0]    b_irow, b_icol;
  logic [1:0]    b_res_row, b_res_col;
  logic [3:0]    b_fidx;
  logic [W-1:0]  b_ifd = '0, b_fd = '0;
  logic [DW-1:0] b_res_data;
  logic [34:0]   b_outs;

  logic [W-1:0] a_img [A_SZ][A_SZ];
  logic [W-1:0] a_filt [NT];
  logic [W-1:0] b_img [B_SZ][B_SZ];
  logic [W-1:0] b_filt [NT];
  int a_got [A_O*A_O];
  int b_got [B_O*B_O];

  assign a_outs = {a_busy, a_done, a_rd_en, a_res_valid, a_res_data, a_res_row, a_res_col, a_irow, a_icol, a_fidx};
  assign b_outs = {b_busy, b_done, b_rd_en, b_res_valid, b_res_data, b_res_row, b_res_col, b_irow, b_icol, b_fidx};

  conv_sequencer #(.IP_DATA_WIDTH(W), .IFMAP_SIZE(A_SZ), .FILTER_SIZE(KS), .STRIDE(A_S)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
    .ifmap_row(a_irow), .ifmap_col(a_icol), .filt_idx(a_fidx),
    .ifmap_rd_data(a_ifd), .filt_rd_data(a_fd),
    .res_valid(a_res_valid), .res_ready(a_ready), .res_data(a_res_data),
    .res_row(a_res_row), .res_col(a_res_col)
  );

  conv_sequencer #(.IP_DATA_WIDTH(W), .IFMAP_SIZE(B_SZ), .FILTER_SIZE(KS), .STRIDE(B_S)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
    .ifmap_row(b_irow), .ifmap_col(b_icol), .filt_idx(b_fidx),
    .ifmap_rd_data(b_ifd), .filt_rd_data(b_fd),
    .res_valid(b_res_valid), .res_ready(b_ready), .res_data(b_res_data),
    .res_row(b_res_row), .res_col(b_res_col)
  );

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (a_rd_en) begin
      a_ifd <= a_img[a_irow][a_icol];
      a_fd  <= a_filt[a_fidx];
    end
    if (b_rd_en) begin
      b_ifd <= b_img[b_irow][b_icol];
      b_fd  <= b_filt[b_fidx];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int a_model(input int r, input int c);
    longint s = 0;
    for (int jj = 0; jj < KS; jj++)
      for (int kk = 0; kk < KS; kk++)
        s += longint'(a_img[r*A_S+jj][c*A_S+kk]) * longint'(a_filt[jj*KS+kk]);
    return int'(s % (64'd1 << DW));
  endfunction

  function automatic int b_model(input int r, input int c);
    longint s = 0;
    for (int jj = 0; jj < KS; jj++)
      for (int kk = 0; kk < KS; kk++)
        s += longint'(b_img[r*B_S+jj][c*B_S+kk]) * longint'(b_filt[jj*KS+kk]);
    return int'(s % (64'd1 << DW));
  endfunction

  // mode 0: ready held high, 1: five stall cycles on window 3, 2: random ready and stray start pulses.
  task automatic run_a(input int mode, input int rst_win, input int rst_tap,
                       output int cyc_first, output int cyc_done, output int nres, output int stalls);
    int cyc, rd_cnt, w, t, e;
    logic held;
    logic [63:0] held_v;
    cyc_first = 0; cyc_done = 0; nres = 0; stalls = 0; rd_cnt = 0; held = 1'b0; held_v = '0;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    cyc = 1;
    while (1) begin
      check("a_busy", a_busy, 1);
      if (a_rd_en) begin
        w = rd_cnt / NT;
        t = rd_cnt % NT;
        check("a_rd_addr", {a_irow, a_icol, a_fidx},
              ((w / A_O) * A_S + t / KS) * 128 + ((w % A_O) * A_S + t % KS) * 16 + t);
        rd_cnt++;
        if (w == rst_win && t == rst_tap) begin
          a_start = 1'b0;
          rst_n = 1'b0;
          #1;
          check("a_async_reset", a_outs, 0);
          @(posedge clk); #1;
          check("a_reset_held", a_outs, 0);
          rst_n = 1'b1;
          a_ready = 1'b1;
          return;
        end
      end else begin
        check("a_addr_zero", {a_irow, a_icol, a_fidx}, 0);
      end
      if (a_res_valid) begin
        if (cyc_first == 0) cyc_first = cyc;
        check("a_rd_en_in_out", a_rd_en, 0);
        if (held) check("a_bp_hold", {a_res_row, a_res_col, a_res_data}, held_v);
        held_v = {a_res_row, a_res_col, a_res_data};
        case (mode)
          1:       a_ready = !(nres == 3 && stalls < 5);
          2:       a_ready = 1'($urandom_range(0, 1));
          default: a_ready = 1'b1;
        endcase
        if (a_ready) begin
          e = a_model(nres / A_O, nres % A_O);
          check("a_result", {a_res_row, a_res_col, a_res_data},
                ((nres / A_O) << 20) | ((nres % A_O) << 17) | e);
          if (nres < A_O * A_O) a_got[nres] = int'(a_res_data);
          nres++;
          held = 1'b0;
        end else begin
          stalls++;
          held = 1'b1;
        end
      end
      if (a_done) begin
        cyc_done = cyc;
        break;
      end
      if (cyc > 4000) begin
        check("a_timeout", 0, 1);
        break;
      end
      if (mode == 2) a_start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    @(posedge clk); #1;
    check("a_done_pulse", {a_busy, a_done}, 0);
  endtask

  task automatic run_b(output int cyc_first, output int cyc_done, output int nres);
    int cyc, rd_cnt, w, t, e;
    cyc_first = 0; cyc_done = 0; nres = 0; rd_cnt = 0;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    cyc = 1;
    while (1) begin
      if (b_rd_en) begin
        w = rd_cnt / NT;
        t = rd_cnt % NT;
        check("b_rd_addr", {b_irow, b_icol, b_fidx},
              ((w / B_O) * B_S + t / KS) * 128 + ((w % B_O) * B_S + t % KS) * 16 + t);
        rd_cnt++;
      end
      if (b_res_valid) begin
        if (cyc_first == 0) cyc_first = cyc;
        e = b_model(nres / B_O, nres % B_O);
        check("b_result", {b_res_row, b_res_col, b_res_data},
              ((nres / B_O) << 19) | ((nres % B_O) << 17) | e);
        if (nres < B_O * B_O) b_got[nres] = int'(b_res_data);
        nres++;
      end
      if (b_done) begin
        cyc_done = cyc;
        break;
      end
      if (cyc > 1000) begin
        check("b_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    check("b_done_pulse", {b_busy, b_done}, 0);
  endtask

  initial begin
    int cf, cd, nr, st, win;
    rst_n = 1'b0;
    a_start = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;
    for (int r = 0; r < A_SZ; r++)
      for (int c = 0; c < A_SZ; c++) a_img[r][c] = W'(8 * r + c);
    for (int r = 0; r < B_SZ; r++)
      for (int c = 0; c < B_SZ; c++) b_img[r][c] = W'(7 * r + c);
    for (int i = 0; i < NT; i++) begin
      a_filt[i] = 8'd1;
      b_filt[i] = 8'd1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_state", a_outs, 0);
    check("b_reset_state", b_outs, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_a(0, -1, 0, cf, cd, nr, st);
    check("a_first_valid_cycle", cf, 11);
    check("a_done_cycle", cd, 397);
    check("a_count", nr, 36);
    check("a_res_0_0", a_got[0], 81);
    check("a_res_0_1", a_got[1], 90);
    check("a_res_5_5", a_got[35], 486);

    for (int r = 0; r < A_SZ; r++)
      for (int c = 0; c < A_SZ; c++) a_img[r][c] = W'($urandom);
    for (int i = 0; i < NT; i++) a_filt[i] = W'($urandom);
    run_a(1, -1, 0, cf, cd, nr, st);
    check("a_bp_stalls", st, 5);
    check("a_bp_count", nr, 36);
    check("a_bp_done_cycle", cd, 402);

    for (int r = 0; r < A_SZ; r++)
      for (int c = 0; c < A_SZ; c++) a_img[r][c] = 8'd255;
    for (int i = 0; i < NT; i++) a_filt[i] = 8'd255;
    run_a(0, -1, 0, cf, cd, nr, st);
    check("a_ovf_count", nr, 36);
    for (int i = 0; i < 36; i++) check("a_ovf_value", a_got[i], 60937);

    for (int r = 0; r < A_SZ; r++)
      for (int c = 0; c < A_SZ; c++) a_img[r][c] = W'($urandom);
    for (int i = 0; i < NT; i++) a_filt[i] = W'($urandom);
    run_a(2, 10, int'($urandom_range(0, NT - 1)), cf, cd, nr, st);
    check("a_rst_win10_results", nr, 10);
    run_a(2, -1, 0, cf, cd, nr, st);
    check("a_restart_count", nr, 36);
    check("a_restart_done_cycle", cd, 397 + st);

    win = int'($urandom_range(0, 35));
    run_a(0, win, int'($urandom_range(0, NT - 1)), cf, cd, nr, st);
    check("a_rst_rand_results", nr, win);
    run_a(0, -1, 0, cf, cd, nr, st);
    check("a_rerun_done_cycle", cd, 397);
    check("a_rerun_count", nr, 36);

    run_b(cf, cd, nr);
    check("b_first_valid_cycle", cf, 11);
    check("b_done_cycle", cd, 100);
    check("b_count", nr, 9);
    check("b_res_0_0", b_got[0], 72);
    check("b_res_1_0", b_got[3], 198);
    check("b_res_2_2", b_got[8], 360);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
